// File: rtl/vga_timing_pkg.sv
// Timing presets, counter-width helper and the flag bundle that travels
// alongside each fetched pixel through the VGA controller.
package vga_timing_pkg;

    // 640x480@60 with a 25.175 MHz pixel clock
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int QVGA_H_ACTIVE = 320;
    localparam int QVGA_H_FP     = 8;
    localparam int QVGA_H_SYNC   = 48;
    localparam int QVGA_H_BP     = 24;
    localparam int QVGA_V_ACTIVE = 240;
    localparam int QVGA_V_FP     = 5;
    localparam int QVGA_V_SYNC   = 2;
    localparam int QVGA_V_BP     = 16;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic border;
        logic h_first;
        logic v_first;
        logic vblank;
    } pix_flags_t;

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical position counters with region and raw sync decode.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = cnt_w(H_TOTAL),
    localparam int VW      = cnt_w(V_TOTAL)
) (
    input  logic          vga_clk,
    input  logic          rst,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hsync_raw,
    output logic          vsync_raw
);

    // Inclusive upper bounds keep every constant inside the counter width.
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_cnt     = h_q;
    assign v_cnt     = v_q;
    assign active    = (h_q <= H_ACT_LAST) && (v_q <= V_ACT_LAST);
    assign hsync_raw = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    assign vsync_raw = (v_q >= VS_FIRST) && (v_q <= VS_LAST);

endmodule

// File: rtl/vga_ctrl_param.sv
// Parametrised VGA controller: frame-buffer fetch addressing, latency-matched
// sync/blank pipeline, border overlay and frame/line status pulses.
module vga_ctrl_param
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int COLOR_W   = 4,
    parameter int FETCH_LAT = 1,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    localparam int AW_COL   = cnt_w(H_ACTIVE),
    localparam int AW_ROW   = cnt_w(V_ACTIVE),
    localparam int PIX_W    = 3 * COLOR_W
) (
    input  logic               vga_clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   d_in,
    input  logic               border_en,
    input  logic [PIX_W-1:0]   border_rgb,
    output logic [AW_ROW-1:0]  row_addr,
    output logic [AW_COL-1:0]  col_addr,
    output logic               rd_en,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               hs,
    output logic               vs,
    output logic               frame_start,
    output logic               line_start,
    output logic               vblank
);

    localparam int HW = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [HW-1:0] COL_LAST = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] ROW_LAST = VW'(V_ACTIVE - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active, hsync_raw, vsync_raw;
    pix_flags_t    fetch_flags, out_flags;

    logic [PIX_W-1:0] rgb_q, rgb_d;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic             fs_q, fs_d, ls_q, ls_d, vb_q, vb_d;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_sync_counter (
        .vga_clk   (vga_clk),
        .rst       (rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .active    (active),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw)
    );

    always_comb begin
        fetch_flags         = '0;
        fetch_flags.active  = active;
        fetch_flags.hsync   = hsync_raw;
        fetch_flags.vsync   = vsync_raw;
        fetch_flags.border  = active && ((h_cnt == '0) || (h_cnt == COL_LAST) ||
                                         (v_cnt == '0) || (v_cnt == ROW_LAST));
        fetch_flags.h_first = (h_cnt == '0);
        fetch_flags.v_first = (v_cnt == '0);
        fetch_flags.vblank  = (v_cnt > ROW_LAST);
        rd_en    = active;
        col_addr = '0;
        row_addr = '0;
        if (active) begin
            col_addr = h_cnt[AW_COL-1:0];
            row_addr = v_cnt[AW_ROW-1:0];
        end
    end

    // Flags wait here for the frame buffer so they meet d_in at the output stage.
    generate
        if (FETCH_LAT == 0) begin : g_no_dly
            assign out_flags = fetch_flags;
        end else begin : g_dly
            pix_flags_t dly_q [FETCH_LAT];
            always_ff @(posedge vga_clk) begin
                if (rst) begin
                    for (int i = 0; i < FETCH_LAT; i++) dly_q[i] <= '0;
                end else begin
                    dly_q[0] <= fetch_flags;
                    for (int i = 1; i < FETCH_LAT; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign out_flags = dly_q[FETCH_LAT-1];
        end
    endgenerate

    always_comb begin
        rgb_d = '0;
        if (out_flags.active) begin
            rgb_d = (border_en && out_flags.border) ? border_rgb : d_in;
        end
        hs_d = out_flags.hsync ? HS_POL : ~HS_POL;
        vs_d = out_flags.vsync ? VS_POL : ~VS_POL;
        fs_d = out_flags.active && out_flags.h_first && out_flags.v_first;
        ls_d = out_flags.active && out_flags.h_first;
        vb_d = out_flags.vblank;
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            rgb_q <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            fs_q  <= 1'b0;
            ls_q  <= 1'b0;
            vb_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= fs_d;
            ls_q  <= ls_d;
            vb_q  <= vb_d;
        end
    end

    assign r           = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign g           = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign b           = rgb_q[COLOR_W-1:0];
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign vblank      = vb_q;

endmodule

// File: tb/tb_vga_ctrl_param.sv
// Directed bench: three small-timing instances (latency 1 and 3, inverted sync
// with border) plus one default 640x480 instance, all on one clock and reset.
module tb_vga_ctrl_param;

    localparam int N_RST = 2469;   // small-timing position (5,2) in frame 19
    localparam int N_END = 2730;

    logic vga_clk = 1'b0;
    logic rst     = 1'b1;
    always #5 vga_clk = ~vga_clk;

    logic [11:0] d_a = 12'hFFF, d_b = 12'hFFF;
    logic [11:0] d_c = 12'h0F0;
    logic        ben_c = 1'b1;

    logic [1:0] row_a, row_b, row_c;
    logic [2:0] col_a, col_b, col_c;
    logic [8:0] row_d;
    logic [9:0] col_d;
    logic       rd_a, rd_b, rd_c, rd_d;
    logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c, r_d, g_d, b_d;
    logic       hs_a, vs_a, fs_a, ls_a, vb_a;
    logic       hs_b, vs_b, fs_b, ls_b, vb_b;
    logic       hs_c, vs_c, fs_c, ls_c, vb_c;
    logic       hs_d, vs_d, fs_d, ls_d, vb_d;

    vga_ctrl_param #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .FETCH_LAT(1)) u_a (
        .vga_clk(vga_clk), .rst(rst), .d_in(d_a), .border_en(1'b0), .border_rgb(12'hF00),
        .row_addr(row_a), .col_addr(col_a), .rd_en(rd_a), .r(r_a), .g(g_a), .b(b_a),
        .hs(hs_a), .vs(vs_a), .frame_start(fs_a), .line_start(ls_a), .vblank(vb_a));

    vga_ctrl_param #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .FETCH_LAT(3)) u_b (
        .vga_clk(vga_clk), .rst(rst), .d_in(d_b), .border_en(1'b0), .border_rgb(12'hF00),
        .row_addr(row_b), .col_addr(col_b), .rd_en(rd_b), .r(r_b), .g(g_b), .b(b_b),
        .hs(hs_b), .vs(vs_b), .frame_start(fs_b), .line_start(ls_b), .vblank(vb_b));

    vga_ctrl_param #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .FETCH_LAT(1),
                     .HS_POL(1'b1), .VS_POL(1'b1)) u_c (
        .vga_clk(vga_clk), .rst(rst), .d_in(d_c), .border_en(ben_c), .border_rgb(12'hF00),
        .row_addr(row_c), .col_addr(col_c), .rd_en(rd_c), .r(r_c), .g(g_c), .b(b_c),
        .hs(hs_c), .vs(vs_c), .frame_start(fs_c), .line_start(ls_c), .vblank(vb_c));

    vga_ctrl_param u_d (
        .vga_clk(vga_clk), .rst(rst), .d_in(12'h000), .border_en(1'b0), .border_rgb(12'hF00),
        .row_addr(row_d), .col_addr(col_d), .rd_en(rd_d), .r(r_d), .g(g_d), .b(b_d),
        .hs(hs_d), .vs(vs_d), .frame_start(fs_d), .line_start(ls_d), .vblank(vb_d));

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
    endtask

    // Expected output of a small-timing instance showing fetch position t
    // (t < 0: still flushing after reset).
    task automatic chk_small(input string p, input int t, input bit pol, input bit ben,
                             input bit coord, input logic [11:0] rgb,
                             input logic hs_o, input logic vs_o, input logic fs_o,
                             input logic ls_o, input logic vb_o);
        int h, v;
        bit act;
        logic [11:0] e_rgb;
        logic e_hs, e_vs, e_fs, e_ls, e_vb;
        e_rgb = 12'h000; e_hs = ~pol; e_vs = ~pol; e_fs = 1'b0; e_ls = 1'b0; e_vb = 1'b0;
        if (t >= 0) begin
            h = t % 16;
            v = (t / 16) % 8;
            act = (h < 8) && (v < 4);
            if (h >= 10 && h < 13) e_hs = pol;
            if (v >= 5 && v < 7) e_vs = pol;
            e_vb = (v >= 4);
            e_fs = act && (h == 0) && (v == 0);
            e_ls = act && (h == 0);
            if (act) begin
                if (ben && (h == 0 || h == 7 || v == 0 || v == 3)) e_rgb = 12'hF00;
                else if (coord) e_rgb = 12'(v * 8 + h);
                else e_rgb = 12'h0F0;
            end
        end
        chk({p, "_rgb"}, 32'(rgb), 32'(e_rgb));
        chk({p, "_hs"}, 32'(hs_o), 32'(e_hs));
        chk({p, "_vs"}, 32'(vs_o), 32'(e_vs));
        chk({p, "_frame_start"}, 32'(fs_o), 32'(e_fs));
        chk({p, "_line_start"}, 32'(ls_o), 32'(e_ls));
        chk({p, "_vblank"}, 32'(vb_o), 32'(e_vb));
    endtask

    initial begin
        logic [11:0] hist_a [4];
        logic [11:0] hist_b [4];
        int n0, k, t, h, v;
        bit act;
        int d_hs_low, a_vs_low, c_vs_high, first_fall;
        logic hs_prev;

        for (int i = 0; i < 4; i++) begin
            hist_a[i] = 12'hFFF;
            hist_b[i] = 12'hFFF;
        end
        n0 = 0; d_hs_low = 0; a_vs_low = 0; c_vs_high = 0; first_fall = -1; hs_prev = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge vga_clk);
            chk_small("rst_a", -1, 1'b0, 1'b0, 1'b1, {r_a, g_a, b_a}, hs_a, vs_a, fs_a, ls_a, vb_a);
            chk_small("rst_b", -1, 1'b0, 1'b0, 1'b1, {r_b, g_b, b_b}, hs_b, vs_b, fs_b, ls_b, vb_b);
            chk_small("rst_c", -1, 1'b1, 1'b1, 1'b0, {r_c, g_c, b_c}, hs_c, vs_c, fs_c, ls_c, vb_c);
            chk("rst_d_hs", 32'(hs_d), 32'd1);
            chk("rst_d_vs", 32'(vs_d), 32'd1);
        end

        for (int n = 0; n < N_END; n++) begin
            if (n > 0) @(negedge vga_clk);
            cyc = n;
            if (n == N_RST + 1) n0 = n;
            k = n - n0;

            h = k % 16;
            v = (k / 16) % 8;
            act = (h < 8) && (v < 4);
            chk("a_rd_en", 32'(rd_a), act ? 32'd1 : 32'd0);
            chk("a_col_addr", 32'(col_a), act ? 32'(h) : 32'd0);
            chk("a_row_addr", 32'(row_a), act ? 32'(v) : 32'd0);

            chk_small("a", k - 2, 1'b0, 1'b0, 1'b1, {r_a, g_a, b_a}, hs_a, vs_a, fs_a, ls_a, vb_a);
            chk_small("b", k - 4, 1'b0, 1'b0, 1'b1, {r_b, g_b, b_b}, hs_b, vs_b, fs_b, ls_b, vb_b);
            chk_small("c", k - 2, 1'b1, ben_c, 1'b0, {r_c, g_c, b_c}, hs_c, vs_c, fs_c, ls_c, vb_c);

            t = k - 2;
            if (t < 0) begin
                chk("d_hs", 32'(hs_d), 32'd1);
                chk("d_vs", 32'(vs_d), 32'd1);
            end else begin
                chk("d_hs", 32'(hs_d), ((t % 800) >= 656 && (t % 800) < 752) ? 32'd0 : 32'd1);
                chk("d_vs", 32'(vs_d),
                    (((t / 800) % 525) >= 490 && ((t / 800) % 525) < 492) ? 32'd0 : 32'd1);
            end

            if (n == 3) chk("b_fs_before_first_pixel", 32'(fs_b), 32'd0);
            if (n == 4) chk("b_fs_first_pixel", 32'(fs_b), 32'd1);
            if (n == N_RST) begin
                chk("pre_rst_col", 32'(col_a), 32'd5);
                chk("pre_rst_row", 32'(row_a), 32'd2);
            end
            if (n == N_RST + 1) begin
                chk("post_rst_rd_en", 32'(rd_a), 32'd1);
                chk("post_rst_col", 32'(col_a), 32'd0);
                chk("post_rst_row", 32'(row_a), 32'd0);
            end
            if (n == N_RST + 3) chk("a_fs_after_rst", 32'(fs_a), 32'd1);
            if (n == N_RST + 5) chk("b_fs_after_rst", 32'(fs_b), 32'd1);

            if (n >= 2 && n < 2402 && hs_d === 1'b0) d_hs_low++;
            if (first_fall < 0 && hs_prev === 1'b1 && hs_d === 1'b0) first_fall = n;
            hs_prev = hs_d;
            if (n >= 2 && n < 130) begin
                if (vs_a === 1'b0) a_vs_low++;
                if (vs_c === 1'b1) c_vs_high++;
            end

            rst   = (n == N_RST);
            ben_c = (n < 1200);
            for (int i = 3; i > 0; i--) begin
                hist_a[i] = hist_a[i-1];
                hist_b[i] = hist_b[i-1];
            end
            hist_a[0] = rd_a ? {7'd0, row_a, col_a} : 12'hFFF;
            hist_b[0] = rd_b ? {7'd0, row_b, col_b} : 12'hFFF;
            d_a = hist_a[1];
            d_b = hist_b[3];
        end

        cyc = -1;
        chk("d_hs_first_fall", 32'(first_fall), 32'd658);
        chk("d_hs_low_3_lines", 32'(d_hs_low), 32'd288);
        chk("a_vs_low_per_frame", 32'(a_vs_low), 32'd32);
        chk("c_vs_high_per_frame", 32'(c_vs_high), 32'd32);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
